// File: rtl/multi_hash_engine_if.sv
// ---------------------------------------------------------------------------
// multi_hash_engine_if
// Purpose : key-chunk stream and hash-result handshake for multi_hash_engine.
// Signals : key_data/key_valid/key_last/key_ready - chunked key input
//           hash_out/hash_valid/hash_ready         - packed per-channel results
// Modports: master - key source / result consumer
//           slave  - the hash engine
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface multi_hash_engine_if #(
   parameter int WORD_WIDTH   = 32,
   parameter int NUM_HASH     = 10,
   parameter int OUTPUT_WIDTH = 19
);
   logic [WORD_WIDTH-1:0]            key_data;
   logic                             key_valid;
   logic                             key_last;
   logic                             key_ready;
   logic [NUM_HASH*OUTPUT_WIDTH-1:0] hash_out;
   logic                             hash_valid;
   logic                             hash_ready;

   modport master (
      output key_data, key_valid, key_last, hash_ready,
      input  key_ready, hash_out, hash_valid
   );

   modport slave (
      input  key_data, key_valid, key_last, hash_ready,
      output key_ready, hash_out, hash_valid
   );
endinterface

// File: rtl/multi_hash_engine.sv
// ---------------------------------------------------------------------------
// multi_hash_engine
// Purpose : NUM_HASH independent seeded CRC-32 hashes over a multi-word key
//           streamed in WORD_WIDTH chunks (MSB byte first). Each channel keeps
//           the low OUTPUT_WIDTH CRC bits in a valid/ready output register.
// Ports   : clk         - clock
//           reset       - asynchronous active-low reset
//           kif         - slave side of the key stream / result handshake
//           hash_seed   - per-channel CRC init, channel i at [32i+31:32i]
//           keys_hashed - count of consumed results (wraps)
//           busy        - a key is partially accumulated
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module multi_hash_engine #(
   parameter int          WORD_WIDTH   = 32,
   parameter int          NUM_HASH     = 10,
   parameter int          OUTPUT_WIDTH = 19,
   parameter logic [31:0] POLY         = 32'h04C11DB7
) (
   input  logic                     clk,
   input  logic                     reset,
   multi_hash_engine_if.slave       kif,
   input  logic [NUM_HASH*32-1:0]   hash_seed,
   output logic [31:0]              keys_hashed,
   output logic                     busy
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_ACCUM = 1'b1
   } state_t;

   state_t                           state_r;
   logic                             busy_r;
   logic [31:0]                      crc_r      [NUM_HASH];
   logic [31:0]                      next_crc_s [NUM_HASH];
   logic [NUM_HASH*OUTPUT_WIDTH-1:0] out_pack_s;
   logic [NUM_HASH*OUTPUT_WIDTH-1:0] hash_out_r;
   logic                             hash_valid_r;
   logic [31:0]                      keys_hashed_r;
   logic                             key_ready_s;
   logic                             accept_s;
   logic                             load_s;
   logic                             consume_s;

   // Non-reflected MSB-first CRC over one whole chunk; unrolls to an XOR tree.
   function automatic logic [31:0] crc_step(input logic [31:0]           crc_in,
                                            input logic [WORD_WIDTH-1:0] data);
      logic [31:0] crc;
      logic        fb;
      crc = crc_in;
      for (int b = WORD_WIDTH - 1; b >= 0; b--) begin
         fb  = crc[31] ^ data[b];
         crc = {crc[30:0], 1'b0} ^ (fb ? POLY : 32'h0000_0000);
      end
      return crc;
   endfunction

   // The output slot is free when empty or being drained this cycle.
   assign key_ready_s = reset & (~hash_valid_r | kif.hash_ready);
   assign accept_s    = kif.key_valid & key_ready_s;
   assign load_s      = accept_s & kif.key_last;
   assign consume_s   = hash_valid_r & kif.hash_ready;

   assign kif.key_ready  = key_ready_s;
   assign kif.hash_out   = hash_out_r;
   assign kif.hash_valid = hash_valid_r;
   assign keys_hashed    = keys_hashed_r;
   assign busy           = busy_r;

   // Next CRC per channel: the first chunk of a key starts from the live seed,
   // later chunks continue from the running state (seed changes mid-key ignored).
   always_comb begin
      for (int i = 0; i < NUM_HASH; i++) begin
         next_crc_s[i] = 32'h0000_0000;
         if (state_r == ST_ACCUM) begin
            next_crc_s[i] = crc_step(crc_r[i], kif.key_data);
         end else begin
            next_crc_s[i] = crc_step(hash_seed[32*i +: 32], kif.key_data);
         end
      end
   end

   // Pack the truncated per-channel results into the output bus layout.
   always_comb begin
      out_pack_s = {(NUM_HASH*OUTPUT_WIDTH){1'b0}};
      for (int i = 0; i < NUM_HASH; i++) begin
         out_pack_s[i*OUTPUT_WIDTH +: OUTPUT_WIDTH] = next_crc_s[i][OUTPUT_WIDTH-1:0];
      end
   end

   // Key framing FSM: IDLE between keys, ACCUM while a key is partially seen.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s && !kif.key_last) begin
                  state_r <= ST_ACCUM;
                  busy_r  <= 1'b1;
               end else begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end
            end
            ST_ACCUM: begin
               if (load_s) begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end else begin
                  state_r <= ST_ACCUM;
                  busy_r  <= 1'b1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   // Running CRC state advances on every accepted chunk.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_HASH; i++) begin
            crc_r[i] <= 32'h0000_0000;
         end
      end else if (accept_s) begin
         for (int i = 0; i < NUM_HASH; i++) begin
            crc_r[i] <= next_crc_s[i];
         end
      end
   end

   // Output register: a new last chunk reloads it even while the old result
   // drains on the same edge, so hash_valid stays high at full rate.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hash_out_r   <= {(NUM_HASH*OUTPUT_WIDTH){1'b0}};
         hash_valid_r <= 1'b0;
      end else if (load_s) begin
         hash_out_r   <= out_pack_s;
         hash_valid_r <= 1'b1;
      end else if (consume_s) begin
         hash_valid_r <= 1'b0;
      end
   end

   // Count results taken by the downstream stage; wraps naturally.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         keys_hashed_r <= 32'h0000_0000;
      end else if (consume_s) begin
         keys_hashed_r <= keys_hashed_r + 32'd1;
      end
   end

endmodule

// File: tb/tb_multi_hash_engine.sv
// ---------------------------------------------------------------------------
// tb_multi_hash_engine
// Randomised and directed stimulus on the default configuration, checked every
// cycle against a key-level model (byte list + table-driven CRC), plus a
// byte-wide instance checked against the CRC-32/MPEG-2 check value.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_multi_hash_engine;

   localparam int          W    = 32;
   localparam int          N    = 10;
   localparam int          OW   = 19;
   localparam int          W8   = 8;
   localparam int          N8   = 2;
   localparam int          OW8  = 32;
   localparam logic [31:0] POLY = 32'h04C11DB7;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [N*32-1:0]   hash_seed;
   logic [31:0]       keys_hashed;
   logic              busy;
   logic [N8*32-1:0]  hash_seed8;
   logic [31:0]       keys_hashed8;
   logic              busy8;

   int errors = 0;
   int checks = 0;

   multi_hash_engine_if #(.WORD_WIDTH(W),  .NUM_HASH(N),  .OUTPUT_WIDTH(OW))  kif();
   multi_hash_engine_if #(.WORD_WIDTH(W8), .NUM_HASH(N8), .OUTPUT_WIDTH(OW8)) kif8();

   multi_hash_engine #(.WORD_WIDTH(W), .NUM_HASH(N), .OUTPUT_WIDTH(OW), .POLY(POLY)) dut (
      .clk(clk), .reset(reset), .kif(kif), .hash_seed(hash_seed),
      .keys_hashed(keys_hashed), .busy(busy)
   );

   multi_hash_engine #(.WORD_WIDTH(W8), .NUM_HASH(N8), .OUTPUT_WIDTH(OW8), .POLY(POLY)) dut8 (
      .clk(clk), .reset(reset), .kif(kif8), .hash_seed(hash_seed8),
      .keys_hashed(keys_hashed8), .busy(busy8)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [31:0]      crc_tab [256];
   logic             m_inkey;
   logic             m_valid;
   logic [31:0]      m_count;
   logic [31:0]      m_seed [N];
   logic [7:0]       m_bytes [$];
   logic [N*OW-1:0]  m_out;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic build_table();
      logic [31:0] c;
      for (int b = 0; b < 256; b++) begin
         c = 32'(b) << 24;
         for (int k = 0; k < 8; k++) begin
            c = c[31] ? ((c << 1) ^ POLY) : (c << 1);
         end
         crc_tab[b] = c;
      end
   endtask

   function automatic logic [31:0] model_crc(input logic [31:0] seed, input logic [7:0] q [$]);
      logic [31:0] c;
      c = seed;
      foreach (q[k]) begin
         c = (c << 8) ^ crc_tab[c[31:24] ^ q[k]];
      end
      return c;
   endfunction

   task automatic model_clear();
      m_inkey = 1'b0;
      m_valid = 1'b0;
      m_count = 32'd0;
      m_out   = '0;
      m_bytes.delete();
   endtask

   // Check outputs mid-cycle, then advance the model across the next edge.
   task automatic step(output bit accepted);
      logic m_ready;
      logic [31:0] c;
      @(negedge clk);
      m_ready = !m_valid || kif.hash_ready;
      check("key_ready", 256'(kif.key_ready), 256'(m_ready));
      check("hash_valid", 256'(kif.hash_valid), 256'(m_valid));
      check("busy", 256'(busy), 256'(m_inkey));
      check("keys_hashed", 256'(keys_hashed), 256'(m_count));
      if (m_valid) check("hash_out", 256'(kif.hash_out), 256'(m_out));
      accepted = kif.key_valid && m_ready;
      if (m_valid && kif.hash_ready) begin
         m_count = m_count + 32'd1;
         m_valid = 1'b0;
      end
      if (accepted) begin
         if (!m_inkey) begin
            for (int i = 0; i < N; i++) m_seed[i] = hash_seed[32*i +: 32];
         end
         for (int k = W/8 - 1; k >= 0; k--) m_bytes.push_back(kif.key_data[8*k +: 8]);
         if (kif.key_last) begin
            for (int i = 0; i < N; i++) begin
               c = model_crc(m_seed[i], m_bytes);
               m_out[i*OW +: OW] = c[OW-1:0];
            end
            m_valid = 1'b1;
            m_inkey = 1'b0;
            m_bytes.delete();
         end else begin
            m_inkey = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_chunk(input logic [W-1:0] data, input logic last);
      bit acc;
      int n;
      kif.key_data  = data;
      kif.key_last  = last;
      kif.key_valid = 1'b1;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 100) begin
         step(acc);
         n++;
      end
      if (!acc) check("accept_timeout", 256'd0, 256'd1);
      kif.key_valid = 1'b0;
      kif.key_last  = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      bit acc;
      kif.key_valid = 1'b0;
      for (int i = 0; i < n; i++) step(acc);
   endtask

   // Asynchronous reset applied between edges; checks the cleared state.
   task automatic do_reset();
      kif.key_valid  = 1'b0;
      kif.key_last   = 1'b0;
      kif8.key_valid = 1'b0;
      kif8.key_last  = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      model_clear();
      check("rst_hash_valid", 256'(kif.hash_valid), 256'd0);
      check("rst_busy", 256'(busy), 256'd0);
      check("rst_keys_hashed", 256'(keys_hashed), 256'd0);
      check("rst_hash_out", 256'(kif.hash_out), 256'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bit          acc;
      string       s;
      logic [7:0]  q8 [$];
      logic [31:0] c;

      build_table();
      model_clear();
      kif.key_data   = '0;
      kif.key_valid  = 1'b0;
      kif.key_last   = 1'b0;
      kif.hash_ready = 1'b1;
      kif8.key_data  = '0;
      kif8.key_valid = 1'b0;
      kif8.key_last  = 1'b0;
      kif8.hash_ready = 1'b0;
      hash_seed      = '0;
      hash_seed8     = {32'h0000_0000, 32'hFFFF_FFFF};
      @(posedge clk);
      #1;
      do_reset();

      // CRC-32/MPEG-2 check value on the byte-wide instance.
      s = "123456789";
      for (int i = 0; i < 9; i++) begin
         kif8.key_data  = s[i];
         kif8.key_valid = 1'b1;
         kif8.key_last  = (i == 8);
         q8.push_back(s[i]);
         @(posedge clk);
         #1;
      end
      kif8.key_valid = 1'b0;
      kif8.key_last  = 1'b0;
      check("mpeg2_valid", 256'(kif8.hash_valid), 256'd1);
      check("mpeg2_check", 256'(kif8.hash_out[31:0]), 256'(32'h0376E6E7));
      c = model_crc(32'h0000_0000, q8);
      check("mpeg2_seed0", 256'(kif8.hash_out[63:32]), 256'(c));
      kif8.hash_ready = 1'b1;
      @(posedge clk);
      #1;
      check("mpeg2_count", 256'(keys_hashed8), 256'd1);
      check("mpeg2_drained", 256'(kif8.hash_valid), 256'd0);

      // Zero seeds, four zero chunks.
      hash_seed = '0;
      for (int i = 0; i < 4; i++) send_chunk('0, i == 3);
      check("zero_valid", 256'(kif.hash_valid), 256'd1);
      check("zero_hash", 256'(kif.hash_out), 256'd0);
      idle_cycles(1);
      check("zero_count", 256'(keys_hashed), 256'd1);

      // Backpressure: result held while a second key stalls.
      kif.hash_ready = 1'b0;
      for (int i = 0; i < N; i++) hash_seed[32*i +: 32] = $urandom();
      send_chunk($urandom(), 1'b1);
      kif.key_data  = $urandom();
      kif.key_valid = 1'b1;
      kif.key_last  = 1'b0;
      for (int i = 0; i < 5; i++) step(acc);
      kif.hash_ready = 1'b1;
      send_chunk(kif.key_data, 1'b0);
      kif.hash_ready = 1'b0;
      send_chunk($urandom(), 1'b1);
      idle_cycles(3);
      kif.hash_ready = 1'b1;
      idle_cycles(2);

      // Back-to-back single-chunk keys at full rate.
      kif.key_valid = 1'b1;
      kif.key_last  = 1'b1;
      for (int i = 0; i < 20; i++) begin
         kif.key_data = $urandom();
         for (int j = 0; j < N; j++) hash_seed[32*j +: 32] = $urandom();
         step(acc);
      end
      idle_cycles(2);

      // Reset mid-key, then a fresh key.
      for (int i = 0; i < 2; i++) send_chunk($urandom(), 1'b0);
      do_reset();
      for (int i = 0; i < 4; i++) send_chunk($urandom(), i == 3);
      idle_cycles(2);
      check("post_reset_count", 256'(keys_hashed), 256'd1);

      // Random traffic with seeds changing every cycle.
      for (int i = 0; i < 3000; i++) begin
         kif.key_valid  = ($urandom_range(0, 9) < 7);
         kif.key_last   = ($urandom_range(0, 3) == 0);
         kif.key_data   = $urandom();
         kif.hash_ready = ($urandom_range(0, 9) < 6);
         for (int j = 0; j < N; j++) hash_seed[32*j +: 32] = $urandom();
         step(acc);
      end
      kif.hash_ready = 1'b1;
      idle_cycles(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/multi_hash_engine.md
Name: multi_hash_engine

Overview:
- Parametrised successor to the single-word header hasher. Computes NUM_HASH independent CRC-based hashes over a multi-word key (e.g. a 104-bit 5-tuple) that is streamed in WORD_WIDTH chunks.
- Each hash channel uses a runtime-programmable 32-bit seed.
- Results are held in an output register under valid/ready backpressure, and the block counts completed keys.
- Sits between the header parser and the sketch counter-update stages.

Parameters:
WORD_WIDTH, 32, key chunk width in bits; multiple of 8, 8..64
NUM_HASH, 10, number of parallel hash channels, 1..16
OUTPUT_WIDTH, 19, bits kept per hash (CRC bits [OUTPUT_WIDTH-1:0]), 1..32
POLY, 32'h04C11DB7, CRC-32 generator polynomial shared by all channels

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
key_data  in  WORD_WIDTH  key chunk; the most significant byte is hashed first
key_valid  in  1  key_data is valid
key_last  in  1  final chunk of the current key
key_ready  out  1  block accepts a chunk this cycle
hash_seed  in  NUM_HASH*32  per-channel CRC init; channel i uses bits [32i+31:32i]
hash_out  out  NUM_HASH*OUTPUT_WIDTH  channel i result in bits [OUTPUT_WIDTH*i +: OUTPUT_WIDTH]
hash_valid  out  1  hash_out holds a completed result
hash_ready  in  1  downstream consumes the result
keys_hashed  out  32  count of results consumed; wraps modulo 2^32
busy  out  1  a key is partially accumulated (FSM in ACCUM)

Behaviour:
- Reset (reset=0, asynchronous): FSM=IDLE, all CRC state=0, hash_out=0, hash_valid=0, keys_hashed=0, busy=0. key_ready is combinational and equals 1 while reset is deasserted and the output is free.
- Chunk accept: a chunk is accepted when key_valid && key_ready at a clk edge.
- key_ready = !hash_valid || hash_ready. This allows back-to-back keys at full rate, one chunk per cycle.
- CRC step: non-reflected, MSB-first, no final XOR. crc_next = CRC(POLY) of WORD_WIDTH data bits applied to the current state. It is a combinational function of WORD_WIDTH; no LUTs.
- FSM IDLE:
  - On accept, each channel's running state becomes step(seed_i, key_data). hash_seed is sampled on this cycle only.
  - If key_last is also high, the result goes directly to the output register and the FSM stays in IDLE.
  - Otherwise the FSM goes to ACCUM.
- FSM ACCUM:
  - On accept, state_i becomes step(state_i, key_data).
  - If key_last: load the output register and return to IDLE.
  - hash_seed changes while in ACCUM are ignored.
- Output load: hash_out_i <= step(...)[OUTPUT_WIDTH-1:0] and hash_valid <= 1 on the edge that accepts the last chunk. Latency from the last chunk to hash_valid is 1 cycle.
- hash_valid clear: hash_valid falls on the edge where hash_valid && hash_ready, unless a new last chunk is accepted on the same edge. In that case hash_out reloads and hash_valid stays 1.
- Output stability: hash_out is stable while hash_valid && !hash_ready.
- keys_hashed increments by 1 on each edge where hash_valid && hash_ready. 32'hFFFFFFFF wraps to 0.
- busy = (FSM == ACCUM).
- Reset mid-key: the partial key is discarded; no hash is produced for it.
- key_valid low while in ACCUM: state is held; no timeout.
- Any number of chunks per key ≥ 1 is allowed. Partial last chunks are not supported: the source zero-pads the last chunk and hashing covers the full chunk.

Test Plan:
- Zero seeds, WORD_WIDTH=32, 4 chunks of 32'h0 (last on 4th) -> one hash_valid pulse 1 cycle after 4th accept; all channels 0; keys_hashed=1.
- WORD_WIDTH=8, OUTPUT_WIDTH=32, seed_0=32'hFFFFFFFF, ASCII "123456789" as 9 chunks -> hash_0=32'h0376E6E7 (CRC-32/MPEG-2 check value).
- Same key hashed twice with seed_1=0xFFFFFFFF and seed_1=0x00000000 -> the two results differ. The second matches the golden C model. Seed changes mid-key do not alter the result.
- hash_ready held low 5 cycles while a second key streams -> key_ready drops after the second key's chunks stall; the first hash_out holds unchanged; no result is lost. keys_hashed goes 0->1->2 as hash_ready pulses.
- Back-to-back single-chunk keys with key_last=1 every cycle and hash_ready=1 -> hash_valid continuously high; one new result per cycle; keys_hashed increments every cycle.
- reset pulsed low after 2 of 4 chunks, then a full key is sent -> the output matches a fresh key only; busy=0 right after reset; keys_hashed=0 then 1.
